// File: rtl/txn_sequencer.sv
// OUT-transaction sequencer: token, data, handshake with bounded retry.
// Optional per-state watchdog is built when TXN_WATCHDOG_EN is defined.
module txn_sequencer #(
  parameter int MAX_RETRY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       token_done,
  input  logic       data_done,
  input  logic       hs_ack,
  input  logic       hs_nak,
  input  logic       hs_fail,
  output logic       send_token,
  output logic       send_data,
  output logic       receive_hand,
  output logic       done,
  output logic       success,
  output logic       error,
  output logic [3:0] retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_DATA,
    S_HAND,
    S_WAIT_HAND,
    S_FINISH_OK,
    S_FINISH_ERR
  } state_t;

  state_t     r_state;
  logic [3:0] r_retry;
  logic [4:0] w_retry_inc;
  logic       w_retry_last;
  logic       w_hs_retry;
  logic       w_wdog_exp;

  assign w_retry_inc  = {1'b0, r_retry} + 5'd1;
  assign w_retry_last = (w_retry_inc >= 5'(MAX_RETRY));
  assign w_hs_retry   = hs_nak | hs_fail;

`ifdef TXN_WATCHDOG_EN
  logic [7:0] r_wdog;
  logic       w_wait_hold;

  // Counter runs only while a waiting state keeps waiting; any other cycle
  // zeroes it, so every entry into TOKEN/DATA/WAIT_HAND starts from 0.
  assign w_wait_hold = ((r_state == S_TOKEN)     && !token_done) ||
                       ((r_state == S_DATA)      && !data_done)  ||
                       ((r_state == S_WAIT_HAND) && !(hs_ack | hs_nak | hs_fail));
  assign w_wdog_exp  = (r_wdog == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= 8'd0;
    end else if (!pause) begin
      r_wdog <= w_wait_hold ? (r_wdog + 8'd1) : 8'd0;
    end
  end
`else
  assign w_wdog_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_retry <= 4'd0;
    end else if (!pause) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_TOKEN;
            r_retry <= 4'd0;
          end
        end
        S_TOKEN: begin
          if (token_done)      r_state <= S_DATA;
          else if (w_wdog_exp) r_state <= S_FINISH_ERR;
        end
        S_DATA: begin
          if (data_done)       r_state <= S_HAND;
          else if (w_wdog_exp) r_state <= S_FINISH_ERR;
        end
        S_HAND: r_state <= S_WAIT_HAND;
        S_WAIT_HAND: begin
          // ack wins over nak/fail; the retry budget counts every attempt made
          if (hs_ack) begin
            r_state <= S_FINISH_OK;
          end else if (w_hs_retry) begin
            r_retry <= w_retry_inc[3:0];
            r_state <= w_retry_last ? S_FINISH_ERR : S_TOKEN;
          end else if (w_wdog_exp) begin
            r_state <= S_FINISH_ERR;
          end
        end
        S_FINISH_OK:  r_state <= S_IDLE;
        S_FINISH_ERR: r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end

  assign send_token   = !pause && (r_state == S_TOKEN);
  assign send_data    = !pause && (r_state == S_DATA);
  assign receive_hand = !pause && (r_state == S_HAND);
  assign success      = !pause && (r_state == S_FINISH_OK);
  assign error        = !pause && (r_state == S_FINISH_ERR);
  assign done         = success | error;
  assign retry_cnt    = r_retry;

endmodule

// File: tb/tb_txn_sequencer.sv
// Self-checking bench for txn_sequencer: two instances (MAX_RETRY 8 and 3),
// a transaction-level expectation model, directed cases then random traffic.
module tb_txn_sequencer;

  logic clk = 1'b0;
  logic rst, start, pause, token_done, data_done, hs_ack, hs_nak, hs_fail;
  logic sel;
  logic st8, st3;
  logic tok8, dat8, rh8, dn8, ok8, er8;
  logic tok3, dat3, rh3, dn3, ok3, er3;
  logic [3:0] rc8, rc3;
  logic [9:0] obs;

  localparam logic [5:0] F_IDLE = 6'b000000;
  localparam logic [5:0] F_TOK  = 6'b100000;
  localparam logic [5:0] F_DAT  = 6'b010000;
  localparam logic [5:0] F_RH   = 6'b001000;
  localparam logic [5:0] F_OK   = 6'b000110;
  localparam logic [5:0] F_ERR  = 6'b000101;

  int checks = 0;
  int errors = 0;
  int exp_retry;
  int held [2];
  int max_r;
  int rand_pause;
  int dt, dd, dh;
  int data_pause_at, data_pause_len;
  int res_q [$];

  always #5 clk = ~clk;

  // only the selected instance ever sees start, so the other idles
  assign st8 = start & ~sel;
  assign st3 = start & sel;
  assign obs = sel ? {tok3, dat3, rh3, dn3, ok3, er3, rc3}
                   : {tok8, dat8, rh8, dn8, ok8, er8, rc8};

  txn_sequencer #(.MAX_RETRY(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .pause(pause),
    .token_done(token_done), .data_done(data_done),
    .hs_ack(hs_ack), .hs_nak(hs_nak), .hs_fail(hs_fail),
    .send_token(tok8), .send_data(dat8), .receive_hand(rh8),
    .done(dn8), .success(ok8), .error(er8), .retry_cnt(rc8)
  );

  txn_sequencer #(.MAX_RETRY(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(st3), .pause(pause),
    .token_done(token_done), .data_done(data_done),
    .hs_ack(hs_ack), .hs_nak(hs_nak), .hs_fail(hs_fail),
    .send_token(tok3), .send_data(dat3), .receive_hand(rh3),
    .done(dn3), .success(ok3), .error(er3), .retry_cnt(rc3)
  );

  function automatic logic [9:0] ev(input logic [5:0] flags, input int r);
    return {flags, 4'(r)};
  endfunction

  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  task automatic check(input string tag, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inputs are already set; check at negedge, then advance past the next edge
  task automatic step(input string tag, input logic [9:0] exp);
    @(negedge clk);
    check(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    start = 0; token_done = 0; data_done = 0;
    hs_ack = 0; hs_nak = 0; hs_fail = 0;
  endtask

  // randomise every input the current phase must ignore; ph 3 = all of them
  task automatic noise(input int ph);
    start      = rb();
    token_done = (ph == 0) ? 1'b0 : rb();
    data_done  = (ph == 1) ? 1'b0 : rb();
    hs_ack     = (ph == 2) ? 1'b0 : rb();
    hs_nak     = (ph == 2) ? 1'b0 : rb();
    hs_fail    = (ph == 2) ? 1'b0 : rb();
  endtask

  task automatic pause_burst(input int n);
    for (int k = 0; k < n; k++) begin
      noise(3);
      pause = 1;
      step("pause", ev(F_IDLE, exp_retry));
    end
    pause = 0;
  endtask

  task automatic wait_phase(input int ph, input int d, input int res,
                            input int pause_at, input int pause_len);
    logic [5:0] flags;
    string tag;
    flags = (ph == 0) ? F_TOK : (ph == 1) ? F_DAT : F_IDLE;
    tag   = (ph == 0) ? "token" : (ph == 1) ? "data" : "wait_hand";
    for (int i = 0; i <= d; i++) begin
      if (i == pause_at) pause_burst(pause_len);
      else if (rand_pause != 0 && $urandom_range(0, 5) == 0)
        pause_burst(int'($urandom_range(1, 3)));
      noise(ph);
      if (i == d) begin
        case (ph)
          0: token_done = 1;
          1: data_done = 1;
          default: begin
            hs_ack  = (res == 0) || (res == 3);
            hs_nak  = (res == 1) || (res == 3);
            hs_fail = (res == 2);
          end
        endcase
      end
      step(tag, ev(flags, exp_retry));
    end
    clr_inputs();
  endtask

  task automatic hand_phase();
    noise(3);
    step("hand", ev(F_RH, exp_retry));
    clr_inputs();
  endtask

  task automatic begin_txn();
    max_r = sel ? 3 : 8;
    exp_retry = held[sel];
    clr_inputs();
    start = 1;
    step("idle_start", ev(F_IDLE, exp_retry));
    start = 0;
    exp_retry = 0;
  endtask

  task automatic end_txn();
    clr_inputs();
    step("idle_after", ev(F_IDLE, exp_retry));
    held[sel] = exp_retry;
  endtask

  // one full transaction: results come from res_q, or random when it is empty
  task automatic run_txn();
    int res;
    begin_txn();
    for (int a = 0; a < 16; a++) begin
      wait_phase(0, (dt >= 0) ? dt : int'($urandom_range(0, 4)), 0, -1, 0);
      wait_phase(1, (dd >= 0) ? dd : int'($urandom_range(0, 4)), 0,
                 data_pause_at, data_pause_len);
      hand_phase();
      if (res_q.size() > 0) res = res_q.pop_front();
      else if ($urandom_range(0, 5) < 2) res = $urandom_range(0, 1) == 0 ? 0 : 3;
      else res = int'($urandom_range(1, 2));
      wait_phase(2, (dh >= 0) ? dh : int'($urandom_range(0, 4)), res, -1, 0);
      if (res == 0 || res == 3) begin
        noise(3);
        step("finish_ok", ev(F_OK, exp_retry));
        break;
      end
      exp_retry++;
      if (exp_retry == max_r) begin
        noise(3);
        step("finish_err", ev(F_ERR, exp_retry));
        break;
      end
    end
    end_txn();
  endtask

`ifdef TXN_WATCHDOG_EN
  task automatic wd_wait(input int ph, input int pause_at);
    logic [5:0] flags;
    flags = (ph == 0) ? F_TOK : (ph == 1) ? F_DAT : F_IDLE;
    for (int i = 0; i < 256; i++) begin
      if (i == pause_at) pause_burst(5);
      noise(ph);
      step("wd_wait", ev(flags, exp_retry));
    end
    noise(3);
    step("wd_err", ev(F_ERR, exp_retry));
  endtask
`endif

  initial begin
    clr_inputs();
    rst = 1; pause = 0; sel = 0;
    held[0] = 0; held[1] = 0; exp_retry = 0;
    rand_pause = 0; dt = -1; dd = -1; dh = -1;
    data_pause_at = -1; data_pause_len = 0;
    @(posedge clk); #1;
    step("reset", ev(F_IDLE, 0));
    start = 1; pause = 1;
    step("rst_prio", ev(F_IDLE, 0));
    rst = 0;
    step("pause_idle", ev(F_IDLE, 0));
    pause = 0; start = 0;
    step("idle", ev(F_IDLE, 0));

    // nominal timing: token_done@3, data_done@6, hs_ack@10
    dt = 2; dd = 2; dh = 2;
    res_q = '{0};
    run_txn();
    dt = -1; dd = -1; dh = -1;

    sel = 1;
    res_q = '{1, 1, 1};
    run_txn();
    sel = 0;

    res_q = '{1, 2, 0};
    run_txn();

    res_q = '{1, 3};
    run_txn();

    data_pause_at = 1; data_pause_len = 5; dd = 3;
    res_q = '{0};
    run_txn();
    data_pause_at = -1; dd = -1;

    rand_pause = 1;
    for (int t = 0; t < 30; t++) begin
      sel = rb();
      run_txn();
    end
    rand_pause = 0;
    sel = 0;

    // reset while waiting for a handshake with two retries used
    begin_txn();
    for (int a = 0; a < 3; a++) begin
      wait_phase(0, 1, 0, -1, 0);
      wait_phase(1, 1, 0, -1, 0);
      hand_phase();
      if (a < 2) begin
        wait_phase(2, 1, 1, -1, 0);
        exp_retry++;
      end
    end
    noise(2);
    step("wait_hand", ev(F_IDLE, exp_retry));
    rst = 1;
    step("rst_wait", ev(F_IDLE, exp_retry));
    rst = 0;
    clr_inputs();
    exp_retry = 0;
    step("post_rst", ev(F_IDLE, 0));
    step("post_rst2", ev(F_IDLE, 0));
    held[0] = 0;

`ifdef TXN_WATCHDOG_EN
    begin_txn();
    wd_wait(0, -1);
    end_txn();
    begin_txn();
    wait_phase(0, 0, 0, -1, 0);
    wd_wait(1, 100);
    end_txn();
    begin_txn();
    wait_phase(0, 0, 0, -1, 0);
    wait_phase(1, 0, 0, -1, 0);
    hand_phase();
    wait_phase(2, 0, 2, -1, 0);
    exp_retry++;
    wait_phase(0, 0, 0, -1, 0);
    wait_phase(1, 0, 0, -1, 0);
    hand_phase();
    wd_wait(2, -1);
    end_txn();
`else
    dt = 300;
    res_q = '{0};
    run_txn();
    dt = -1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
